// File: rtl/eth_rx_slot_buf_pkg.sv
// Shared definitions for the Ethernet receive slot buffer: register map,
// write FSM states, CRC constants and STATUS field placement per data width.
package eth_rx_slot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } rx_state_e;

  localparam int unsigned REG_STATUS = 0;
  localparam int unsigned REG_RXLEN  = 1;
  localparam int unsigned REG_POP    = 2;
  localparam int unsigned REG_CTRL   = 3;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam int unsigned STAT_NONEMPTY_BIT = 0;
  localparam int unsigned STAT_COUNT_LSB    = 8;
  localparam int unsigned STAT_HEAD_LSB_W64 = 16;
  localparam int unsigned STAT_DROP_LSB_W64 = 32;
  localparam int unsigned STAT_HEAD_LSB_W32 = 4;
  localparam int unsigned STAT_DROP_LSB_W32 = 16;

  function automatic int unsigned stat_head_lsb(input int unsigned dw);
    return (dw == 32) ? STAT_HEAD_LSB_W32 : STAT_HEAD_LSB_W64;
  endfunction

  function automatic int unsigned stat_drop_lsb(input int unsigned dw);
    return (dw == 32) ? STAT_DROP_LSB_W32 : STAT_DROP_LSB_W64;
  endfunction

endpackage

// File: rtl/eth_rx_slot_buf_if.sv
// Memory-port bundle between the core (master) and the receive slot buffer (slave).
interface eth_rx_slot_buf_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 15
);
  logic                    req;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input rdata);
  modport slave  (input req, we, addr, be, wdata, output rdata);
endinterface

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 update (no final inversion).
module eth_crc32
  import eth_rx_slot_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_next = c;
  end
endmodule

// File: rtl/eth_rx_slot_buf.sv
// Multi-slot receive frame buffer with ring status registers and drop counting.
// Optional FCS checking is enabled by defining ETH_RX_FCS_CHECK_EN.
module eth_rx_slot_buf
  import eth_rx_slot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_BYTES = 2048,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_last_i,
  input  logic             rx_err_i,
  eth_rx_slot_buf_if.slave mem,
  output logic             irq_o
);
  localparam int unsigned BPW      = DATA_WIDTH / 8;
  localparam int unsigned LB       = $clog2(BPW);
  localparam int unsigned SW       = $clog2(NUM_SLOTS);
  localparam int unsigned OW       = $clog2(SLOT_BYTES);
  localparam int unsigned CW       = $clog2(NUM_SLOTS + 1);
  localparam int unsigned WW       = SW + OW - LB;
  localparam int unsigned DEPTH    = NUM_SLOTS * SLOT_BYTES / BPW;
  localparam int unsigned REG_BASE = NUM_SLOTS * SLOT_BYTES;
  localparam int unsigned HEAD_LSB = stat_head_lsb(DATA_WIDTH);
  localparam int unsigned DROP_LSB = stat_drop_lsb(DATA_WIDTH);
  localparam logic [OW:0]   OFF_END  = (OW + 1)'(SLOT_BYTES);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);

  rx_state_e             state_q, state_d;
  logic [OW:0]           off_q, off_d;
  logic [SW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;
  logic [15:0]           drop_q;
  logic                  rx_en_q, irq_en_q, irq_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_val, status;
  logic [15:0]           len_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] store_q [DEPTH];

  logic                  wr_en, commit, drop_inc, pop, ctrl_wr, full, nonempty;
  logic                  fcs_ok, in_buf;
  logic [15:0]           commit_len;
  logic [WW-1:0]         wr_word, rd_word;
  logic [ADDR_WIDTH-1:0] reg_off, reg_word;
  logic                  unused;

  assign full     = (count_q == FULL_CNT);
  assign nonempty = (count_q != '0);
  assign wr_word  = {tail_q, off_q[OW-1:LB]};
  assign rd_word  = mem.addr[SW+OW-1:LB];
  assign in_buf   = (mem.addr < ADDR_WIDTH'(REG_BASE));
  assign reg_off  = mem.addr - ADDR_WIDTH'(REG_BASE);
  assign reg_word = reg_off >> LB;
  assign pop      = mem.req && mem.we && !in_buf && mem.be[0] && nonempty &&
                    (reg_word == ADDR_WIDTH'(REG_POP));
  assign ctrl_wr  = mem.req && mem.we && !in_buf && mem.be[0] &&
                    (reg_word == ADDR_WIDTH'(REG_CTRL));
  assign unused   = ^{mem.wdata[DATA_WIDTH-1:2], mem.be[BPW-1:1]};

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0] crc_q, crc_seed, crc_next;

  // Each frame seeds from the init value on its first byte, seen while still in IDLE.
  assign crc_seed = (state_q == IDLE) ? CRC_INIT : crc_q;

  eth_crc32 u_crc (.crc(crc_seed), .data(rx_data_i), .crc_next(crc_next));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      crc_q <= CRC_INIT;
    else if (wr_en) crc_q <= crc_next;
  end

  assign fcs_ok     = (crc_next == CRC_RESIDUE);
  assign commit_len = 16'(off_q) - 16'd3;
`else
  assign fcs_ok     = 1'b1;
  assign commit_len = 16'(off_q) + 16'd1;
`endif

  // off_q is held at zero outside RECV, so it is the store offset in IDLE too.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE, RECV: begin
        if (rx_valid_i) begin
          if (state_q == IDLE && !rx_en_q) begin
            state_d = rx_last_i ? IDLE : DROP;
          end else if ((state_q == IDLE) ? full : (off_q == OFF_END)) begin
            drop_inc = 1'b1;
            state_d  = rx_last_i ? IDLE : DROP;
          end else begin
            wr_en   = 1'b1;
            off_d   = off_q + 1'b1;
            state_d = RECV;
            if (rx_last_i) begin
              state_d = IDLE;
              if (rx_err_i || !fcs_ok) drop_inc = 1'b1;
              else                     commit   = 1'b1;
            end
          end
        end
      end
      DROP: if (rx_valid_i && rx_last_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != RECV) off_d = '0;
  end

  always_comb begin
    status = '0;
    status[STAT_NONEMPTY_BIT]   = nonempty;
    status[STAT_COUNT_LSB +: 5] = 5'(count_q);
    status[HEAD_LSB +: 4]       = 4'(head_q);
    status[DROP_LSB +: 16]      = drop_q;
  end

  always_comb begin
    rd_val = '0;
    if (in_buf) begin
      rd_val = store_q[rd_word];
    end else begin
      case (reg_word)
        ADDR_WIDTH'(REG_STATUS): rd_val = status;
        ADDR_WIDTH'(REG_RXLEN):  rd_val = nonempty ? DATA_WIDTH'(len_q[head_q]) : '0;
        ADDR_WIDTH'(REG_CTRL):   rd_val = DATA_WIDTH'({irq_en_q, rx_en_q});
        default:                 rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      off_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      rx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      if (commit) tail_q <= tail_q + 1'b1;
      if (pop)    head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(commit) - CW'(pop);
      if (drop_inc && drop_q != '1) drop_q <= drop_q + 16'd1;
      if (ctrl_wr) {irq_en_q, rx_en_q} <= mem.wdata[1:0];
      irq_q <= irq_en_q && nonempty;
      if (mem.req && !mem.we) rdata_q <= rd_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en)  store_q[wr_word][{off_q[LB-1:0], 3'b000} +: 8] <= rx_data_i;
    if (commit) len_q[tail_q] <= commit_len;
  end

  assign mem.rdata = rdata_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_eth_rx_slot_buf.sv
// Directed bench for eth_rx_slot_buf (default build, 64-bit port, 4 slots of 2048 bytes).
module tb_eth_rx_slot_buf;
  localparam logic [14:0] A_STATUS = 15'h2000;
  localparam logic [14:0] A_RXLEN  = 15'h2008;
  localparam logic [14:0] A_POP    = 15'h2010;
  localparam logic [14:0] A_CTRL   = 15'h2018;
  localparam logic [14:0] A_UNMAP  = 15'h2020;

  typedef struct {
    string       name;
    logic [14:0] addr;
    logic [63:0] exp;
  } rd_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid, rx_last, rx_err, irq;
  logic [7:0] rx_data;
  int         n_tests = 0;
  int         n_fail  = 0;

  eth_rx_slot_buf_if #(.DATA_WIDTH(64), .ADDR_WIDTH(15)) bus ();

  eth_rx_slot_buf #(
    .DATA_WIDTH(64),
    .NUM_SLOTS(4),
    .SLOT_BYTES(2048),
    .ADDR_WIDTH(15)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_valid_i(rx_valid),
    .rx_data_i(rx_data),
    .rx_last_i(rx_last),
    .rx_err_i(rx_err),
    .mem(bus),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [14:0] a, output logic [63:0] d);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
    tick();
    bus.req = 1'b0;
    d = bus.rdata;
  endtask

  task automatic bus_write(input logic [14:0] a, input logic [63:0] wd, input logic [7:0] be);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = wd; bus.be = be;
    tick();
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [14:0] a, input logic [63:0] exp);
    logic [63:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic send_frame(input int unsigned len, input logic [7:0] start, input logic err);
    for (int unsigned i = 0; i < len; i++) begin
      rx_valid = 1'b1;
      rx_data  = start + 8'(i);
      rx_last  = (i == len - 1);
      rx_err   = err && (i == len - 1);
      tick();
    end
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rd_vec_t vecs[8];
    vecs[0] = '{"a_status", A_STATUS, 64'h0000_0000_0000_0101};
    vecs[1] = '{"a_rxlen",  A_RXLEN,  64'd60};
    vecs[2] = '{"a_word0",  15'h0000, 64'h0706_0504_0302_0100};
    vecs[3] = '{"a_word1",  15'h0008, 64'h0F0E_0D0C_0B0A_0908};
    vecs[4] = '{"a_word6",  15'h0030, 64'h3736_3534_3332_3130};
    vecs[5] = '{"a_ctrl",   A_CTRL,   64'h1};
    vecs[6] = '{"a_pop_rd", A_POP,    64'h0};
    vecs[7] = '{"a_unmap",  A_UNMAP,  64'h0};

    // Reset values, sampled while reset is held.
    rst = 1'b1;
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
    tick();
    tick();
    check("rst_rdata", bus.rdata, 64'h0);
    check("rst_irq", {63'h0, irq}, 64'h0);
    rst = 1'b0;
    tick();
    check_rd("rst_status", A_STATUS, 64'h0);
    check_rd("rst_ctrl", A_CTRL, 64'h0);

    // A: one 60-byte frame, then a table of reads; a buffer write must be ignored.
    bus_write(A_CTRL, 64'h1, 8'hFF);
    send_frame(60, 8'h00, 1'b0);
    bus_write(15'h0000, '1, 8'hFF);
    for (int i = 0; i < 8; i++) check_rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
    check("a_irq_off", {63'h0, irq}, 64'h0);

    // B: five frames into four slots, then pop and wrap into slot 0.
    do_reset();
    bus_write(A_CTRL, 64'h1, 8'hFF);
    for (int unsigned f = 0; f < 5; f++) send_frame(10 + f, 8'(16 * f), 1'b0);
    check_rd("b_status_full", A_STATUS, 64'h0000_0001_0000_0401);
    check_rd("b_rxlen0", A_RXLEN, 64'd10);
    bus_write(A_POP, 64'h1, 8'h01);
    send_frame(20, 8'hA0, 1'b0);
    check_rd("b_status_wrap", A_STATUS, 64'h0000_0001_0001_0401);
    check_rd("b_rxlen1", A_RXLEN, 64'd11);
    check_rd("b_slot0_word0", 15'h0000, 64'hA7A6_A5A4_A3A2_A1A0);
    for (int i = 0; i < 3; i++) bus_write(A_POP, 64'h1, 8'h01);
    check_rd("b_rxlen_wrapped", A_RXLEN, 64'd20);

    // C: disabled receive, errored frame, oversize frame, then recovery.
    do_reset();
    send_frame(6, 8'h10, 1'b0);
    check_rd("c_disabled", A_STATUS, 64'h0);
    bus_write(A_CTRL, 64'h1, 8'hFF);
    send_frame(8, 8'h20, 1'b1);
    check_rd("c_err", A_STATUS, 64'h0000_0001_0000_0000);
    send_frame(2049, 8'h00, 1'b0);
    check_rd("c_oversize", A_STATUS, 64'h0000_0002_0000_0000);
    send_frame(5, 8'h30, 1'b0);
    check_rd("c_recover", A_STATUS, 64'h0000_0002_0000_0101);
    check_rd("c_rxlen", A_RXLEN, 64'd5);

    // D: commit and pop in the same cycle with two frames held.
    do_reset();
    bus_write(A_CTRL, 64'h1, 8'hFF);
    send_frame(3, 8'h00, 1'b0);
    send_frame(4, 8'h10, 1'b0);
    for (int unsigned i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h50 + i); rx_last = 1'b0;
      tick();
    end
    rx_data = 8'h55; rx_last = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = A_POP; bus.wdata = 64'h1; bus.be = 8'hFF;
    tick();
    rx_valid = 1'b0; rx_last = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    check_rd("d_status", A_STATUS, 64'h0000_0000_0001_0201);
    check_rd("d_rxlen", A_RXLEN, 64'd4);
    bus_write(A_POP, 64'h1, 8'h01);
    check_rd("d_rxlen_tail", A_RXLEN, 64'd6);

    // E: interrupt timing on commit and on pop.
    do_reset();
    bus_write(A_CTRL, 64'h3, 8'hFF);
    send_frame(4, 8'h00, 1'b0);
    check("e_irq_c1", {63'h0, irq}, 64'h0);
    tick();
    check("e_irq_c2", {63'h0, irq}, 64'h1);
    bus_write(A_POP, 64'h1, 8'h01);
    check("e_irq_pop_c1", {63'h0, irq}, 64'h1);
    tick();
    check("e_irq_pop_c2", {63'h0, irq}, 64'h0);

    // F: reset arriving 20 bytes into a frame.
    do_reset();
    bus_write(A_CTRL, 64'h3, 8'hFF);
    send_frame(8, 8'h00, 1'b0);
    tick();
    check_rd("f_status_pre", A_STATUS, 64'h0000_0000_0000_0101);
    check("f_irq_pre", {63'h0, irq}, 64'h1);
    for (int unsigned i = 0; i < 20; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i); rx_last = 1'b0;
      tick();
    end
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("f_rst_rdata", bus.rdata, 64'h0);
    check("f_rst_irq", {63'h0, irq}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check_rd("f_status_post", A_STATUS, 64'h0);
    bus_write(A_CTRL, 64'h1, 8'hFF);
    send_frame(9, 8'h40, 1'b0);
    check_rd("f_status_new", A_STATUS, 64'h0000_0000_0000_0101);
    check_rd("f_rxlen_new", A_RXLEN, 64'd9);
    check_rd("f_word0_new", 15'h0000, 64'h4746_4544_4342_4140);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
